arch_retire_scheduler: RTL and testbench

- Sits between the reorder buffer head and the architectural register file write ports.
- Each cycle it takes up to RETIRE_WIDTH in-order retiring entries and packs their register writes onto NUM_WR_PORTS physical write ports. It also drops writes that are dead within the same group (same-cycle WAW) and writes to x0.
- Owns the register-file clear sequence after reset or on request, zeroing all NUM_AREGS entries through the write ports. The register file itself therefore needs no bulk reset.

---
 rtl/arch_retire_scheduler.sv | 117 +++++++++++
 tb/tb_arch_retire_scheduler.sv | 138 +++++++++++++
 2 files changed

// File: rtl/arch_retire_scheduler.sv
// arch_retire_scheduler: packs in-order ROB retirements onto register file write ports and owns the register file clear sequence.
module arch_retire_scheduler #(
    parameter int RETIRE_WIDTH = 4,
    parameter int NUM_WR_PORTS = 2,
    parameter int NUM_AREGS    = 32,
    parameter int AREG_W       = $clog2(NUM_AREGS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [RETIRE_WIDTH-1:0]          rob_valid,
    input  logic [RETIRE_WIDTH-1:0]          rob_has_dest,
    input  logic [RETIRE_WIDTH*AREG_W-1:0]   rob_dest_reg,
    input  logic [RETIRE_WIDTH*32-1:0]       rob_result,
    input  logic                             clear_req,
    output logic [$clog2(RETIRE_WIDTH+1)-1:0] retire_cnt,
    output logic [NUM_WR_PORTS-1:0]          wr_valid,
    output logic [NUM_WR_PORTS*AREG_W-1:0]   wr_addr,
    output logic [NUM_WR_PORTS*32-1:0]       wr_data,
    output logic                             init_done
);
    localparam int CW = $clog2(RETIRE_WIDTH + 1);
    typedef enum logic {INIT, RUN} state_t;
    state_t                        state;
    logic [AREG_W:0]               cnt, cnt_nxt;
    logic [RETIRE_WIDTH-1:0]       need, acc, surv;
    logic [CW:0]                   used;
    logic [CW-1:0]                 acc_n;
    logic [CW-1:0]                 rank [RETIRE_WIDTH];
    logic                          stop;
    logic [NUM_WR_PORTS-1:0]       pv;
    logic [NUM_WR_PORTS*AREG_W-1:0] pa, ia;
    logic [NUM_WR_PORTS*32-1:0]    pd;
    // accept the valid prefix while the pre-suppression port demand fits
    always_comb begin
        used  = '0;
        acc_n = '0;
        stop  = 1'b0;
        acc   = '0;
        need  = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            need[i] = rob_has_dest[i] && rob_dest_reg[i*AREG_W +: AREG_W] != '0;
            if (!stop && rob_valid[i] && used + (CW+1)'(need[i]) <= (CW+1)'(NUM_WR_PORTS)) begin
                acc[i] = 1'b1;
                used   = used + (CW+1)'(need[i]);
                acc_n  = acc_n + CW'(1);
            end else begin
                stop = 1'b1;
            end
        end
    end
    // a younger accepted write to the same register kills the older one
    always_comb begin
        surv = acc & need;
        for (int i = 0; i < RETIRE_WIDTH; i++)
            for (int j = i + 1; j < RETIRE_WIDTH; j++)
                if (acc[j] && need[j] && rob_dest_reg[j*AREG_W +: AREG_W] == rob_dest_reg[i*AREG_W +: AREG_W])
                    surv[i] = 1'b0;
    end
    always_comb begin
        rank[0] = '0;
        for (int i = 1; i < RETIRE_WIDTH; i++)
            rank[i] = rank[i-1] + CW'(surv[i-1]);
    end
    always_comb begin
        pv = '0;
        pa = '0;
        pd = '0;
        for (int p = 0; p < NUM_WR_PORTS; p++)
            for (int i = 0; i < RETIRE_WIDTH; i++)
                if (surv[i] && rank[i] == CW'(p)) begin
                    pv[p]                  = 1'b1;
                    pa[p*AREG_W +: AREG_W] = rob_dest_reg[i*AREG_W +: AREG_W];
                    pd[p*32 +: 32]         = rob_result[i*32 +: 32];
                end
    end
    always_comb begin
        ia = '0;
        for (int p = 0; p < NUM_WR_PORTS; p++)
            ia[p*AREG_W +: AREG_W] = cnt[AREG_W-1:0] + AREG_W'(p);
    end
    assign cnt_nxt    = cnt + (AREG_W+1)'(NUM_WR_PORTS);
    assign retire_cnt = (!rst || state == INIT || clear_req) ? '0 : acc_n;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= INIT;
            cnt       <= '0;
            wr_valid  <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            init_done <= 1'b0;
        end else if (state == INIT) begin
            wr_valid <= '1;
            wr_addr  <= ia;
            wr_data  <= '0;
            if (clear_req) begin
                cnt <= '0;
            end else if (cnt_nxt == (AREG_W+1)'(NUM_AREGS)) begin
                cnt       <= '0;
                state     <= RUN;
                init_done <= 1'b1;
            end else begin
                cnt <= cnt_nxt;
            end
        end else if (clear_req) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
            wr_valid  <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_valid <= pv;
            wr_addr  <= pa;
            wr_data  <= pd;
        end
    end
endmodule

// File: tb/tb_arch_retire_scheduler.sv
// tb_arch_retire_scheduler: directed checks of clear sequence, retire packing, WAW and x0 suppression.
module tb_arch_retire_scheduler;
    localparam int AW = 5;
    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    rob_valid, rob_has_dest;
    logic [19:0]   rob_dest_reg;
    logic [127:0]  rob_result;
    logic          clear_req;
    logic [2:0]    retire_cnt;
    logic [1:0]    wr_valid;
    logic [9:0]    wr_addr;
    logic [63:0]   wr_data;
    logic          init_done;
    int checks = 0, failures = 0;

    arch_retire_scheduler dut (
        .clk(clk), .rst(rst), .rob_valid(rob_valid), .rob_has_dest(rob_has_dest),
        .rob_dest_reg(rob_dest_reg), .rob_result(rob_result), .clear_req(clear_req),
        .retire_cnt(retire_cnt), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input int i, input logic v, input logic hd, input logic [AW-1:0] d, input logic [31:0] r);
        rob_valid[i]            = v;
        rob_has_dest[i]         = hd;
        rob_dest_reg[i*AW +: AW] = d;
        rob_result[i*32 +: 32]  = r;
    endtask

    task automatic run_init(input int n, input bit last);
        for (int c = 0; c < n; c++) begin
            #1;
            chk("init_rc", retire_cnt, 0);
            tick;
            chk("init_v", wr_valid, 2'b11);
            chk("init_a", wr_addr, {AW'(2*c+1), AW'(2*c)});
            chk("init_d", wr_data, 0);
            chk("init_done", init_done, last && c == n-1);
        end
    endtask

    initial begin
        rst = 1'b0; clear_req = 1'b0;
        rob_valid = '0; rob_has_dest = '0; rob_dest_reg = '0; rob_result = '0;
        tick; tick;
        chk("rst_v", wr_valid, 0);
        chk("rst_a", wr_addr, 0);
        chk("rst_done", init_done, 0);
        chk("rst_rc", retire_cnt, 0);
        slot(0, 1, 1, 5, 32'h55); slot(1, 1, 1, 6, 32'h66);
        slot(2, 1, 1, 7, 32'h77); slot(3, 1, 1, 8, 32'h88);
        rst = 1'b1;
        run_init(16, 1);
        #1;
        chk("rc_full", retire_cnt, 2);
        tick;
        chk("full_v", wr_valid, 2'b11);
        chk("full_a", wr_addr, {AW'(6), AW'(5)});
        chk("full_d", wr_data, {32'h66, 32'h55});
        slot(0, 1, 1, 3, 32'hA); slot(1, 1, 0, 7, 32'h1);
        slot(2, 1, 1, 0, 32'h2); slot(3, 1, 1, 9, 32'hB);
        #1;
        chk("rc_x0", retire_cnt, 4);
        tick;
        chk("x0_v", wr_valid, 2'b11);
        chk("x0_a", wr_addr, {AW'(9), AW'(3)});
        chk("x0_d", wr_data, {32'hB, 32'hA});
        slot(0, 1, 1, 4, 32'h1); slot(1, 1, 1, 4, 32'h2);
        slot(2, 0, 1, 12, 32'h3); slot(3, 1, 1, 10, 32'h4);
        #1;
        chk("rc_waw", retire_cnt, 2);
        tick;
        chk("waw_v", wr_valid, 2'b01);
        chk("waw_a", wr_addr, {AW'(0), AW'(4)});
        chk("waw_d", wr_data, {32'h0, 32'h2});
        slot(0, 1, 1, 1, 32'h11); slot(1, 1, 1, 2, 32'h22);
        slot(2, 1, 0, 0, 32'h33); slot(3, 1, 1, 0, 32'h44);
        #1;
        chk("rc_free", retire_cnt, 4);
        tick;
        chk("free_v", wr_valid, 2'b11);
        chk("free_a", wr_addr, {AW'(2), AW'(1)});
        rob_valid = 4'b0000;
        #1;
        chk("rc_idle", retire_cnt, 0);
        tick;
        chk("idle_v", wr_valid, 0);
        chk("idle_a", wr_addr, 0);
        chk("idle_d", wr_data, 0);
        rob_valid = 4'b1111;
        clear_req = 1'b1;
        #1;
        chk("rc_clr", retire_cnt, 0);
        tick;
        clear_req = 1'b0;
        chk("clr_done", init_done, 0);
        chk("clr_v", wr_valid, 0);
        run_init(5, 0);
        clear_req = 1'b1;
        #1;
        chk("rc_reclr", retire_cnt, 0);
        tick;
        clear_req = 1'b0;
        chk("reclr_a", wr_addr, {AW'(11), AW'(10)});
        run_init(16, 1);
        clear_req = 1'b1;
        tick;
        clear_req = 1'b0;
        run_init(7, 0);
        rst = 1'b0;
        #1;
        chk("mrst_rc", retire_cnt, 0);
        tick;
        chk("mrst_v", wr_valid, 0);
        chk("mrst_a", wr_addr, 0);
        chk("mrst_done", init_done, 0);
        rst = 1'b1;
        run_init(16, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
